// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for mem_ctrl: access-length codes, FSM state encoding, bus widths.
package mem_ctrl_pkg;

  localparam logic [1:0] MEM_LEN_BYTE = 2'b00;
  localparam logic [1:0] MEM_LEN_HALF = 2'b01;
  localparam logic [1:0] MEM_LEN_WORD = 2'b10;

  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  // Index of the last byte of an access; code 11 behaves as a word.
  function automatic logic [2:0] len_last(input logic [1:0] len);
    case (len)
      MEM_LEN_BYTE: len_last = 3'd0;
      MEM_LEN_HALF: len_last = 3'd1;
      default:      len_last = 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_load_ext.sv
// Combinational load-result extender: byte/half zero- or sign-extended to 32 bits, word passed through.
module mem_load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  len_i,
  input  logic        signed_i,
  output logic [31:0] ext_o
);

  always_comb begin
    ext_o = raw_i;
    case (len_i)
      MEM_LEN_BYTE: ext_o = {{24{signed_i & raw_i[7]}},  raw_i[7:0]};
      MEM_LEN_HALF: ext_o = {{16{signed_i & raw_i[15]}}, raw_i[15:0]};
      default:      ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller between the MEM stage and an 8-bit synchronous RAM.
// Optional instruction-fetch port enabled by defining MEM_CTRL_IF_PORT_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  mem_signed,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [1:0]            mem_len,
  input  logic [31:0]           mem_w_data,
  output logic [31:0]           mem_r_data,
  output logic                  mem_done,
  input  logic [7:0]            ram_din,
  output logic [7:0]            ram_dout,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_wr
`ifdef MEM_CTRL_IF_PORT_EN
  ,
  input  logic                  if_read,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [31:0]           if_inst,
  output logic                  if_done
`endif
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2:0]            LAT      = 3'(RAM_RD_LAT);

  mem_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
  logic [7:0]            ram_dout_q, ram_dout_d;
  logic                  ram_wr_q, ram_wr_d;
  logic [31:0]           r_data_q, r_data_d;
  logic [1:0]            len_q, len_d;
  logic                  signed_q, signed_d;
  logic [23:0]           wdata_q, wdata_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:0]           rbuf_q, rbuf_d;
  logic [2:0]            rd_idx;
  logic [31:0]           rd_raw;
  logic [31:0]           rd_ext;
  logic                  data_req;
  logic                  is_fetch;

  assign data_req = mem_read | mem_write;

`ifdef MEM_CTRL_IF_PORT_EN
  logic        fetch_q, fetch_d;
  logic [31:0] if_inst_q, if_inst_d;
  assign is_fetch = fetch_q;
  assign if_inst  = if_inst_q;
  assign if_done  = !if_read | (state_q == ST_DONE && fetch_q);
`else
  assign is_fetch = 1'b0;
`endif

  // Completion is reported only to the requester that owns the access.
  assign mem_done   = !data_req | (state_q == ST_DONE && !is_fetch);
  assign mem_r_data = r_data_q;
  assign ram_a      = ram_a_q;
  assign ram_dout   = ram_dout_q;
  assign ram_wr     = ram_wr_q;

  // Read buffer with the byte arriving this cycle merged in, so the last byte needs no extra cycle.
  assign rd_idx = cnt_q - LAT;
  always_comb begin
    rd_raw = rbuf_q;
    rd_raw[{rd_idx[1:0], 3'b000} +: 8] = ram_din;
  end

  mem_load_ext u_ext (
    .raw_i    (rd_raw),
    .len_i    (len_q),
    .signed_i (signed_q),
    .ext_o    (rd_ext)
  );

  always_comb begin
    state_d    = state_q;
    ram_a_d    = ram_a_q;
    ram_dout_d = ram_dout_q;
    ram_wr_d   = 1'b0;
    r_data_d   = r_data_q;
    len_d      = len_q;
    signed_d   = signed_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rbuf_d     = rbuf_q;
`ifdef MEM_CTRL_IF_PORT_EN
    fetch_d    = fetch_q;
    if_inst_d  = if_inst_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (data_req) begin
          len_d    = mem_len;
          signed_d = mem_signed;
          ram_a_d  = mem_addr;
          cnt_d    = 3'd0;
          rbuf_d   = '0;
`ifdef MEM_CTRL_IF_PORT_EN
          fetch_d  = 1'b0;
`endif
          if (mem_write) begin
            state_d    = ST_WR;
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_w_data[7:0];
            wdata_d    = mem_w_data[31:8];
          end else begin
            state_d = ST_RD;
          end
        end
`ifdef MEM_CTRL_IF_PORT_EN
        else if (if_read) begin
          fetch_d  = 1'b1;
          len_d    = MEM_LEN_WORD;
          signed_d = 1'b0;
          ram_a_d  = if_addr;
          cnt_d    = 3'd0;
          rbuf_d   = '0;
          state_d  = ST_RD;
        end
`endif
      end
      ST_WR: begin
        if (cnt_q == len_last(len_q)) begin
          state_d = ST_DONE;
        end else begin
          ram_wr_d   = 1'b1;
          ram_a_d    = ram_a_q + ADDR_ONE;
          ram_dout_d = wdata_q[7:0];
          wdata_d    = {8'h00, wdata_q[23:8]};
          cnt_d      = cnt_q + 3'd1;
        end
      end
      ST_RD: begin
        // cnt_q counts RD cycles: address cnt_q goes out, byte cnt_q-LAT comes back.
        if (cnt_q >= LAT) rbuf_d = rd_raw;
        if (cnt_q < len_last(len_q)) ram_a_d = ram_a_q + ADDR_ONE;
        if (cnt_q == len_last(len_q) + LAT) begin
          state_d = ST_DONE;
`ifdef MEM_CTRL_IF_PORT_EN
          if (fetch_q) if_inst_d = rd_raw;
          else         r_data_d  = rd_ext;
`else
          r_data_d = rd_ext;
`endif
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ram_a_q    <= '0;
      ram_dout_q <= '0;
      ram_wr_q   <= 1'b0;
      r_data_q   <= '0;
      len_q      <= '0;
      signed_q   <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rbuf_q     <= '0;
`ifdef MEM_CTRL_IF_PORT_EN
      fetch_q    <= 1'b0;
      if_inst_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ram_a_q    <= ram_a_d;
      ram_dout_q <= ram_dout_d;
      ram_wr_q   <= ram_wr_d;
      r_data_q   <= r_data_d;
      len_q      <= len_d;
      signed_q   <= signed_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rbuf_q     <= rbuf_d;
`ifdef MEM_CTRL_IF_PORT_EN
      fetch_q    <= fetch_d;
      if_inst_q  <= if_inst_d;
`endif
    end
  end

  // Simultaneous load and store is a MEM-stage bug; the store wins.
  a_rw_excl: assert property (@(posedge clk) disable iff (!rst_n) !(mem_read && mem_write));

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: vector table of loads/stores against a byte RAM model, plus reset/back-to-back/fetch sequences.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, mem_signed = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [1:0]  mem_len = '0;
  logic [31:0] mem_w_data = '0;
  logic [31:0] mem_r_data;
  logic        mem_done;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
`ifdef MEM_CTRL_IF_PORT_EN
  logic        if_read = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_inst;
  logic        if_done;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_WIDTH(32), .RAM_RD_LAT(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_signed (mem_signed),
    .mem_addr   (mem_addr),
    .mem_len    (mem_len),
    .mem_w_data (mem_w_data),
    .mem_r_data (mem_r_data),
    .mem_done   (mem_done),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .ram_a      (ram_a),
    .ram_wr     (ram_wr)
`ifdef MEM_CTRL_IF_PORT_EN
    ,
    .if_read    (if_read),
    .if_addr    (if_addr),
    .if_inst    (if_inst),
    .if_done    (if_done)
`endif
  );

  // 256-byte synchronous RAM, one cycle read latency; bench preload goes through the same process.
  logic [7:0] ram [0:255];
  logic       bd_we = 1'b0;
  logic [7:0] bd_a = '0, bd_d = '0;
  logic [7:0] ram_rd_q = '0;
  assign ram_din = ram_rd_q;
  always @(posedge clk) begin
    if (bd_we)       ram[bd_a] <= bd_d;
    else if (ram_wr) ram[ram_a[7:0]] <= ram_dout;
    ram_rd_q <= ram[ram_a[7:0]];
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_a = a; bd_d = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic        sgn;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_done;
  } vec_t;

  // Drives a request just after a rising edge and follows it to mem_done; leaves the request asserted.
  task automatic run(input vec_t v, input string tag);
    int cyc = 0;
    int nb;
    bit seen = 0;
    logic [31:0] a1 = '0, an = '0;
    logic        wr1 = 1'b0;
    nb = (v.len == 2'b00) ? 1 : (v.len == 2'b01) ? 2 : 4;
    mem_read = v.rd; mem_write = v.wr; mem_signed = v.sgn;
    mem_addr = v.addr; mem_len = v.len; mem_w_data = v.wdata;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      if (cyc == 1)  begin a1 = ram_a; wr1 = ram_wr; end
      if (cyc == nb) an = ram_a;
      if (mem_done) seen = 1;
      else cyc++;
    end
    chk({tag, " done_cycle"}, 32'(cyc), 32'(v.exp_done));
    chk({tag, " ram_a_first"}, a1, v.addr);
    chk({tag, " ram_a_last"}, an, v.addr + 32'(nb - 1));
    chk({tag, " ram_wr_c1"}, {31'd0, wr1}, {31'd0, v.wr});
    chk({tag, " r_data"}, mem_r_data, v.exp_rd);
    @(posedge clk); #1;
  endtask

  task automatic idle1();
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h10, 2'b00, 32'h0,        32'hFFFFFF80, 3};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h10, 2'b00, 32'h0,        32'h00000080, 3};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h20, 2'b10, 32'h0,        32'h12345678, 6};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h40, 2'b01, 32'h0,        32'hFFFF857F, 4};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h40, 2'b01, 32'h0,        32'h0000857F, 4};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h31, 2'b01, 32'hAABBCCDD, 32'h0000857F, 3};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h31, 2'b00, 32'h0,        32'h000000DD, 3};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h20, 2'b11, 32'h0,        32'h12345678, 6};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h50, 2'b10, 32'hCAFEF00D, 32'h12345678, 5};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h50, 2'b10, 32'h0,        32'hCAFEF00D, 6};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h33, 2'b00, 32'h0,        32'h0000005A, 3};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 32'h32, 2'b01, 32'h0,        32'h00005ACC, 4};

    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    @(posedge clk); #1;
    poke(8'h10, 8'h80);
    poke(8'h20, 8'h78); poke(8'h21, 8'h56); poke(8'h22, 8'h34); poke(8'h23, 8'h12);
    poke(8'h40, 8'h7F); poke(8'h41, 8'h85);
    poke(8'h33, 8'h5A);
    poke(8'hFE, 8'hEF); poke(8'hFF, 8'hBE); poke(8'h00, 8'hAD); poke(8'h01, 8'hDE);

    // Reset state
    @(negedge clk);
    chk("rst ram_a", ram_a, 32'h0);
    chk("rst ram_dout", {24'd0, ram_dout}, 32'h0);
    chk("rst ram_wr", {31'd0, ram_wr}, 32'h0);
    chk("rst r_data", mem_r_data, 32'h0);
    chk("rst mem_done", {31'd0, mem_done}, 32'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run(vecs[i], $sformatf("vec%0d", i));
      idle1();
    end
    chk("sh ram31", {24'd0, ram[8'h31]}, 32'hDD);
    chk("sh ram32", {24'd0, ram[8'h32]}, 32'hCC);
    chk("sh ram33 untouched", {24'd0, ram[8'h33]}, 32'h5A);

    // Back-to-back store then load, request never dropped.
    run('{1'b0, 1'b1, 1'b0, 32'h60, 2'b10, 32'h0BADF00D, 32'h00005ACC, 5}, "b2b_sw");
    run('{1'b1, 1'b0, 1'b0, 32'h60, 2'b10, 32'h0,        32'h0BADF00D, 6}, "b2b_lw");
    idle1();

    // Reset in cycle 2 of a word store: byte 0 stays written, byte 1 never lands.
    mem_write = 1'b1; mem_read = 1'b0; mem_addr = 32'h70; mem_len = 2'b10; mem_w_data = 32'h11223344;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("mid ram_wr c2", {31'd0, ram_wr}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid rst ram_wr", {31'd0, ram_wr}, 32'h0);
    chk("mid rst ram_a", ram_a, 32'h0);
    chk("mid rst ram_dout", {24'd0, ram_dout}, 32'h0);
    chk("mid rst r_data", mem_r_data, 32'h0);
    chk("mid rst done_req_hi", {31'd0, mem_done}, 32'h0);
    mem_write = 1'b0;
    #1;
    chk("mid rst done_req_lo", {31'd0, mem_done}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid ram70", {24'd0, ram[8'h70]}, 32'h44);
    chk("mid ram71", {24'd0, ram[8'h71]}, 32'h00);
    @(posedge clk); #1;
    run('{1'b1, 1'b0, 1'b0, 32'h20, 2'b10, 32'h0, 32'h12345678, 6}, "post_rst_lw");
    idle1();

`ifdef MEM_CTRL_IF_PORT_EN
    begin
      int cyc = 0;
      bit seen = 0;
      logic [31:0] a1 = '0, a3 = '0, a4 = '0;
      if_read = 1'b1; if_addr = 32'hFFFFFFFE;
      run('{1'b1, 1'b0, 1'b1, 32'h10, 2'b00, 32'h0, 32'hFFFFFF80, 3}, "arb_lb");
      mem_read = 1'b0;
      while (!seen && cyc < 20) begin
        @(negedge clk);
        if (cyc == 1) a1 = ram_a;
        if (cyc == 3) a3 = ram_a;
        if (cyc == 4) a4 = ram_a;
        if (if_done) seen = 1;
        else cyc++;
      end
      chk("fetch done_cycle", 32'(cyc), 32'd6);
      chk("fetch ram_a c1", a1, 32'hFFFFFFFE);
      chk("fetch ram_a wrap0", a3, 32'h0);
      chk("fetch ram_a wrap1", a4, 32'h1);
      chk("fetch if_inst", if_inst, 32'hDEADBEEF);
      chk("fetch r_data kept", mem_r_data, 32'hFFFFFF80);
      @(posedge clk); #1;
      if_read = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
